// File: rtl/imem_loader.sv
// Instruction-memory program loader: turns a length-prefixed byte stream into
// big-endian 32-bit words written from address 0, holding the CPU in reset meanwhile.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_LAST_WR, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_asm;
    logic [15:0]         r_word_idx;
    logic [15:0]         r_word_count;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_last_word;
    logic                w_word_end;

    assign w_accept    = in_valid & in_ready;
    assign w_len       = {r_word_count[15:8], in_data};
    assign w_last_word = (r_word_idx == (r_word_count - 16'd1));
    assign w_word_end  = w_accept && (r_byte_idx == 2'd3);

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_word_count;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured in the three non-busy states
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN_HI;
                else       w_next = r_state;
            end
            S_LEN_HI: begin
                if (w_accept) w_next = S_LEN_LO;
                else          w_next = S_LEN_HI;
            end
            S_LEN_LO: begin
                if (!w_accept)             w_next = S_LEN_LO;
                else if (w_len == 16'd0)   w_next = S_DONE;
                else if (w_len > DEPTH_W)  w_next = S_ERR;
                else                       w_next = S_DATA;
            end
            S_DATA: begin
                if (w_word_end && w_last_word) w_next = S_LAST_WR;
                else                           w_next = S_DATA;
            end
            S_LAST_WR: w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_LAST_WR: busy = 1'b1;
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR:   err = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Header latch, word assembly and the separate write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_word_idx   <= 16'd0;
            r_word_count <= 16'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= {ADDR_W{1'b0}};
            r_wr_data    <= 32'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_word_count <= 16'd0;
                        r_byte_idx   <= 2'd0;
                        r_word_idx   <= 16'd0;
                    end else begin
                        r_word_count <= r_word_count;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) r_word_count[15:8] <= in_data;
                    else          r_word_count <= r_word_count;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_word_count[7:0] <= in_data;
                        r_byte_idx        <= 2'd0;
                        r_word_idx        <= 16'd0;
                    end else begin
                        r_word_count <= r_word_count;
                    end
                end
                S_DATA: begin
                    if (w_word_end) begin
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_word_idx[ADDR_W-1:0];
                        r_wr_data  <= {r_asm, in_data};
                        r_word_idx <= r_word_idx + 16'd1;
                        r_byte_idx <= 2'd0;
                    end else if (w_accept) begin
                        r_asm      <= {r_asm[15:0], in_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end else begin
                        r_asm <= r_asm;
                    end
                end
                default: r_wr_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue that
// a negedge monitor drains whenever wr_en is seen; status is checked inline.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold, busy, done, err;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] sb[$];

    imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst && wr_en) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", wr_addr, wr_data);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                check("wr_addr", {24'd0, wr_addr}, {24'd0, e[39:32]});
                check("wr_data", wr_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input int max_gap, input int start_at);
        int waited;
        foreach (bytes[i]) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                in_valid = 1'b0;
                for (int k = 0; k < g; k++) tick();
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            start    = (i == start_at);
            waited   = 0;
            @(negedge clk);
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL byte_timeout: byte %0d got in_ready=0 expected 1", i);
            end
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #20;
        @(negedge clk);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Two-word load, back-to-back bytes
        sb.push_back({8'd0, 32'hDEADBEEF});
        sb.push_back({8'd1, 32'h00000001});
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01}, 0, -1);
        @(negedge clk);
        check("two_last_in_ready", {31'd0, in_ready}, 32'd0);
        check("two_last_done", {31'd0, done}, 32'd0);
        tick();
        @(negedge clk);
        check("two_done", {31'd0, done}, 32'd1);
        check("two_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("two_busy", {31'd0, busy}, 32'd0);
        check("two_word_count", {16'd0, word_count}, 32'd2);
        check("two_in_ready", {31'd0, in_ready}, 32'd0);

        // Bytes offered in DONE are not consumed
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("done_in_ready", {31'd0, in_ready}, 32'd0);
            check("done_hold", {31'd0, done}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("sb_empty_two", sb.size(), 32'd0);

        // Zero length
        pulse_start();
        send_stream('{8'h00, 8'h00}, 0, -1);
        @(negedge clk);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("zero_word_count", {16'd0, word_count}, 32'd0);
        tick();

        // Overflow: N=257
        pulse_start();
        send_stream('{8'h01, 8'h01}, 0, -1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_word_count", {16'd0, word_count}, 32'h101);
        tick();
        tick();
        @(negedge clk);
        check("ovf_err_sticky", {31'd0, err}, 32'd1);
        in_valid = 1'b0;
        tick();

        // Recovery from ERR reloads address 0
        pulse_start();
        @(negedge clk);
        check("rec_err_clear", {31'd0, err}, 32'd0);
        check("rec_busy", {31'd0, busy}, 32'd1);
        tick();
        sb.push_back({8'd0, 32'h12345678});
        send_stream('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 0, -1);
        tick();
        @(negedge clk);
        check("rec_done", {31'd0, done}, 32'd1);
        check("rec_cpu_hold", {31'd0, cpu_hold}, 32'd0);

        // Stalled stream with a start pulse during DATA
        sb.push_back({8'd0, 32'hDEADBEEF});
        sb.push_back({8'd1, 32'h00000001});
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01}, 3, 5);
        tick();
        @(negedge clk);
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_word_count", {16'd0, word_count}, 32'd2);
        check("sb_empty_stall", sb.size(), 32'd0);
        tick();

        // Abort by reset after the first word's write
        sb.push_back({8'd0, 32'hCAFEF00D});
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 0, -1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_wr_en", {31'd0, wr_en}, 32'd0);
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_consume", {31'd0, in_ready}, 32'd0);
            check("abort_idle_done", {31'd0, done}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("sb_empty_end", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
